// File: rtl/load_dcache.sv
// rtl/load_dcache.sv - direct-mapped, write-through, read-allocate load data cache
// Optional statistics counters (stat_hits/stat_misses) are enabled by defining LOAD_DCACHE_STATS_EN.
module load_dcache #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_read_enable,
  input  logic [WORD_SIZE-1:0] c_ptr,
  output logic                 c_ready,
  output logic [WORD_SIZE-1:0] c_out,
  output logic                 c_hit,
  output logic                 c_valid,
  input  logic                 st_en,
  input  logic [WORD_SIZE-1:0] st_addr,
  input  logic [WORD_SIZE-1:0] st_data,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_waddr,
  output logic [WORD_SIZE-1:0] mem_wdata
`ifdef LOAD_DCACHE_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Line storage: valid bits are reset, tags and data are not.
  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [WORD_SIZE-1:0] data_q [SETS][LINE_WORDS];

  // Outstanding miss: requested address, beat counter, words already written by stores.
  logic [WORD_SIZE-1:0]  req_addr_q, req_addr_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WORDS-1:0] ovr_q, ovr_d;

  // Registered outputs.
  logic                 c_valid_q, c_valid_d;
  logic                 c_hit_q, c_hit_d;
  logic [WORD_SIZE-1:0] c_out_q, c_out_d;
  logic                 mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_waddr_q, mem_waddr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

  // Address fields for the load, the store and the pending miss.
  logic [TAG_W-1:0] ld_tag, st_tag, rq_tag;
  logic [IDX_W-1:0] ld_idx, st_idx, rq_idx;
  logic [OFF_W-1:0] ld_off, st_off, rq_off;

  assign ld_tag = c_ptr[WORD_SIZE-1:OFF_W+IDX_W];
  assign ld_idx = c_ptr[OFF_W+IDX_W-1:OFF_W];
  assign ld_off = c_ptr[OFF_W-1:0];
  assign st_tag = st_addr[WORD_SIZE-1:OFF_W+IDX_W];
  assign st_idx = st_addr[OFF_W+IDX_W-1:OFF_W];
  assign st_off = st_addr[OFF_W-1:0];
  assign rq_tag = req_addr_q[WORD_SIZE-1:OFF_W+IDX_W];
  assign rq_idx = req_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign rq_off = req_addr_q[OFF_W-1:0];

  logic ld_hit, st_hit;
  logic accept, hit_accept, miss_accept;
  logic beat, last_beat;
  logic st_to_refill;
  logic [WORD_SIZE-1:0] resp_word;

  assign ld_hit      = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
  assign st_hit      = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
  assign accept      = (state_q == S_IDLE) && c_read_enable;
  assign hit_accept  = accept && ld_hit;
  assign miss_accept = accept && !ld_hit;
  assign beat        = (state_q == S_REFILL) && mem_rvalid;
  assign last_beat   = beat && (cnt_q == LAST_OFF);

  // A store targets the line being refilled either while the refill runs or in the
  // very cycle the miss is accepted; such words must survive the incoming beats.
  assign st_to_refill = st_en &&
      (((state_q == S_REFILL) &&
        (st_addr[WORD_SIZE-1:OFF_W] == req_addr_q[WORD_SIZE-1:OFF_W])) ||
       (miss_accept && (st_addr[WORD_SIZE-1:OFF_W] == c_ptr[WORD_SIZE-1:OFF_W])));

  // Word returned at the end of a refill: same-cycle store, else the final beat, else storage.
  always_comb begin
    resp_word = data_q[rq_idx][rq_off];
    if (st_en && (st_addr == req_addr_q)) begin
      resp_word = st_data;
    end else if ((rq_off == cnt_q) && !ovr_q[rq_off]) begin
      resp_word = mem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (miss_accept) state_d = S_REFILL;
      S_REFILL: if (last_beat)   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and miss-tracking next values.
  always_comb begin
    c_valid_d   = 1'b0;
    c_hit_d     = 1'b0;
    c_out_d     = c_out_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = st_en;
    mem_waddr_d = st_en ? st_addr : mem_waddr_q;
    mem_wdata_d = st_en ? st_data : mem_wdata_q;
    req_addr_d  = req_addr_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;

    if (hit_accept) begin
      c_valid_d = 1'b1;
      c_hit_d   = 1'b1;
      c_out_d   = (st_en && (st_addr == c_ptr)) ? st_data : data_q[ld_idx][ld_off];
    end

    if (miss_accept) begin
      req_addr_d = c_ptr;
      cnt_d      = '0;
      ovr_d      = '0;
      mem_req_d  = 1'b1;
      mem_addr_d = {c_ptr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
    end

    if (beat) begin
      mem_req_d = 1'b0;
      cnt_d     = cnt_q + OFF_W'(1);
    end

    if (st_to_refill) begin
      ovr_d[st_off] = 1'b1;
    end

    if (last_beat) begin
      c_valid_d = 1'b1;
      c_hit_d   = 1'b0;
      c_out_d   = resp_word;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      req_addr_q  <= '0;
      cnt_q       <= '0;
      ovr_q       <= '0;
      c_valid_q   <= 1'b0;
      c_hit_q     <= 1'b0;
      c_out_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (miss_accept) valid_q[ld_idx] <= 1'b0;
      if (last_beat)   valid_q[rq_idx] <= 1'b1;
      req_addr_q  <= req_addr_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      c_valid_q   <= c_valid_d;
      c_hit_q     <= c_hit_d;
      c_out_q     <= c_out_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays; the store write is last so it beats a same-cycle refill beat.
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_q[rq_idx] <= rq_tag;
    end
    if (beat && !ovr_q[cnt_q]) begin
      data_q[rq_idx][cnt_q] <= mem_rdata;
    end
    if (st_en && (st_hit || st_to_refill)) begin
      data_q[st_idx][st_off] <= st_data;
    end
  end

  assign c_ready   = (state_q == S_IDLE);
  assign c_valid   = c_valid_q;
  assign c_hit     = c_hit_q;
  assign c_out     = c_out_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef LOAD_DCACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q;

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      if (hit_accept && (stat_hits_q != '1))    stat_hits_q   <= stat_hits_q + 32'd1;
      if (miss_accept && (stat_misses_q != '1)) stat_misses_q <= stat_misses_q + 32'd1;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_load_dcache.sv
// tb/tb_load_dcache.sv - randomized self-checking bench for load_dcache against a line-level model
module tb_load_dcache;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_read_enable;
  logic [31:0] c_ptr;
  logic        c_ready;
  logic [31:0] c_out;
  logic        c_hit;
  logic        c_valid;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
`ifdef LOAD_DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  always #5 clk = ~clk;

  load_dcache dut (
    .clk           (clk),
    .reset         (reset),
    .c_read_enable (c_read_enable),
    .c_ptr         (c_ptr),
    .c_ready       (c_ready),
    .c_out         (c_out),
    .c_hit         (c_hit),
    .c_valid       (c_valid),
    .st_en         (st_en),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata)
`ifdef LOAD_DCACHE_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a table of resident lines (by line number) plus the pending miss.
  int          m_mode;            // 0 accepting loads, 1 waiting for line, 2 delivering miss result
  bit          m_lv   [16];
  logic [29:0] m_line [16];
  logic [31:0] m_dat  [16][4];
  logic [31:0] m_req;
  int          m_beats;
  logic [31:0] m_got  [4];
  bit          m_ov   [4];
  logic [31:0] m_ovd  [4];
  logic [31:0] mem [logic [31:0]];
  int          m_hits, m_misses;

  logic        e_ready, e_valid, e_hit, e_req, e_we;
  logic [31:0] e_out, e_maddr, e_waddr, e_wdata;

  function automatic int set_of(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [29:0] line_of(input logic [31:0] a);
    return a[31:2];
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'(a[1:0]);
  endfunction

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) m_lv[s] = 1'b0;
    m_mode = 0; m_hits = 0; m_misses = 0;
    e_ready = 1'b1; e_valid = 1'b0; e_hit = 1'b0; e_out = '0;
    e_req = 1'b0; e_maddr = '0; e_we = 1'b0; e_waddr = '0; e_wdata = '0;
  endtask

  // Consequences of one clock edge with the given inputs.
  task automatic model_step(input logic rd, input logic [31:0] ptr, input logic st,
                            input logic [31:0] sa, input logic [31:0] sd,
                            input logic rv, input logic [31:0] rdat);
    int s;
    e_we = st;
    if (st) begin
      e_waddr = sa; e_wdata = sd; mem[sa] = sd;
    end
    e_valid = 1'b0;
    e_hit   = 1'b0;
    case (m_mode)
      0: if (rd) begin
        s = set_of(ptr);
        if (m_lv[s] && m_line[s] == line_of(ptr)) begin
          e_valid = 1'b1; e_hit = 1'b1;
          e_out = (st && sa == ptr) ? sd : m_dat[s][off_of(ptr)];
          m_hits++;
        end else begin
          m_misses++;
          m_mode = 1; m_req = ptr; m_beats = 0; m_lv[s] = 1'b0;
          for (int k = 0; k < 4; k++) m_ov[k] = 1'b0;
          e_req = 1'b1; e_maddr = {line_of(ptr), 2'b00};
          if (st && line_of(sa) == line_of(ptr)) begin
            m_ov[off_of(sa)] = 1'b1; m_ovd[off_of(sa)] = sd;
          end
        end
      end
      1: begin
        if (st && line_of(sa) == line_of(m_req)) begin
          m_ov[off_of(sa)] = 1'b1; m_ovd[off_of(sa)] = sd;
        end
        if (rv) begin
          e_req = 1'b0;
          m_got[m_beats] = rdat;
          m_beats++;
          if (m_beats == 4) begin
            s = set_of(m_req);
            m_lv[s] = 1'b1; m_line[s] = line_of(m_req);
            for (int k = 0; k < 4; k++) m_dat[s][k] = m_ov[k] ? m_ovd[k] : m_got[k];
            e_valid = 1'b1; e_hit = 1'b0; e_out = m_dat[s][off_of(m_req)];
            m_mode = 2;
          end
        end
      end
      default: m_mode = 0;
    endcase
    if (st) begin
      s = set_of(sa);
      if (m_lv[s] && m_line[s] == line_of(sa)) m_dat[s][off_of(sa)] = sd;
    end
    e_ready = (m_mode == 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("c_ready", c_ready, e_ready);
    chk("c_valid", c_valid, e_valid);
    if (e_valid) begin
      chk("c_hit", c_hit, e_hit);
      chk("c_out", c_out, e_out);
    end
    chk("mem_req", mem_req, e_req);
    if (e_req) chk("mem_addr", mem_addr, e_maddr);
    chk("mem_we", mem_we, e_we);
    if (e_we) begin
      chk("mem_waddr", mem_waddr, e_waddr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
`ifdef LOAD_DCACHE_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_misses);
`endif
  end

  task automatic step(input logic rd, input logic [31:0] ptr, input logic st,
                      input logic [31:0] sa, input logic [31:0] sd,
                      input logic rv, input logic [31:0] rdat);
    c_read_enable = rd; c_ptr = ptr; st_en = st; st_addr = sa; st_data = sd;
    mem_rvalid = rv; mem_rdata = rdat;
    @(posedge clk);
    #1;
    model_step(rd, ptr, st, sa, sd, rv, rdat);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Four refill beats d0..d0+3, with two idle cycles after beat gap_at (-1 for none).
  task automatic beats(input logic [31:0] d0, input int gap_at);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, d0 + 32'(k));
      if (k == gap_at) begin
        idle(); idle();
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return {24'h0, 2'($urandom_range(0, 2)), 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic        rd, st, rv;
    logic [31:0] ptr, sa, sd, rdat;

    reset = 1'b0; c_read_enable = 1'b0; c_ptr = '0; st_en = 1'b0; st_addr = '0;
    st_data = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_reset();
    #2;
    chk("rst_c_ready", c_ready, 32'd1);
    chk("rst_c_valid", c_valid, 32'd0);
    chk("rst_c_out", c_out, 32'd0);
    chk("rst_mem_req", mem_req, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;

    // Scenario 1: cold miss with a gap between beats 1 and 2.
    load(32'h40);
    chk("s1_mem_req", mem_req, 32'd1);
    chk("s1_mem_addr", mem_addr, 32'h40);
    chk("s1_c_ready", c_ready, 32'd0);
    chk("s1_no_valid", c_valid, 32'd0);
    beats(32'hA0, 1);
    chk("s1_c_valid", c_valid, 32'd1);
    chk("s1_c_hit", c_hit, 32'd0);
    chk("s1_c_out", c_out, 32'hA0);
    idle();
    chk("s1_ready_after", c_ready, 32'd1);

    // Scenario 2: back-to-back hits.
    load(32'h41);
    chk("s2_hit1", c_hit, 32'd1);
    chk("s2_out1", c_out, 32'hA1);
    load(32'h43);
    chk("s2_valid2", c_valid, 32'd1);
    chk("s2_out2", c_out, 32'hA3);
    chk("s2_no_req", mem_req, 32'd0);
    idle();
`ifdef LOAD_DCACHE_STATS_EN
    chk("s2_stat_hits", stat_hits, 32'd2);
    chk("s2_stat_misses", stat_misses, 32'd1);
`endif

    // Scenario 3: conflicting line evicts, then reload misses.
    load(32'h80);
    chk("s3_mem_addr", mem_addr, 32'h80);
    beats(32'hB0, -1);
    chk("s3_c_out", c_out, 32'hB0);
    idle();
    load(32'h40);
    chk("s3_remiss", mem_req, 32'd1);
    beats(32'hA0, 2);
    idle();

    // Scenario 4: same-address store forwarding, then different-offset store on a hit.
    step(1'b1, 32'h42, 1'b1, 32'h42, 32'h55, 1'b0, 32'h0);
    chk("s4_hit", c_hit, 32'd1);
    chk("s4_fwd", c_out, 32'h55);
    chk("s4_we", mem_we, 32'd1);
    chk("s4_waddr", mem_waddr, 32'h42);
    chk("s4_wdata", mem_wdata, 32'h55);
    step(1'b1, 32'h40, 1'b1, 32'h41, 32'h66, 1'b0, 32'h0);
    chk("s4_old_word", c_out, 32'hA0);
    load(32'h41);
    chk("s4_new_word", c_out, 32'h66);

    // Scenario 5: store into the line being refilled; store to an uncached line.
    load(32'h101);
    step(1'b0, 32'h0, 1'b1, 32'h101, 32'h77, 1'b1, 32'h10);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h13);
    chk("s5_resp", c_out, 32'h77);
    idle();
    load(32'h101);
    chk("s5_hit", c_hit, 32'd1);
    chk("s5_hit_out", c_out, 32'h77);
    step(1'b0, 32'h0, 1'b1, 32'h200, 32'h99, 1'b0, 32'h0);
    chk("s5_we_addr", mem_waddr, 32'h200);
    load(32'h200);
    chk("s5_no_alloc", mem_req, 32'd1);
    beats(32'h20, -1);
    idle();

    // Scenario 6: reset in the middle of a refill.
    load(32'h300);
    chk("s6_req_before", mem_req, 32'd1);
    c_read_enable = 1'b0; st_en = 1'b0; mem_rvalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("s6_req_drop", mem_req, 32'd0);
    chk("s6_ready", c_ready, 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    load(32'h300);
    chk("s6_remiss", mem_req, 32'd1);
    beats(32'h30, 0);
    idle();

    // Randomized traffic over a small address pool to mix hits, misses and conflicts.
    for (int n = 0; n < 4000; n++) begin
      rd   = 1'($urandom_range(0, 1));
      ptr  = rand_addr();
      st   = ($urandom_range(0, 99) < 35);
      sa   = ($urandom_range(0, 3) == 0) ? ptr : rand_addr();
      sd   = $urandom;
      rv   = 1'b0;
      rdat = $urandom;
      if (m_mode == 1) begin
        rv = ($urandom_range(0, 99) < 60);
        if (rv) rdat = memrd({line_of(m_req), 2'b00} + 32'(m_beats));
      end
      step(rd, ptr, st, sa, sd, rv, rdat);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
